// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serial transmit stage of a 16550-style UART.
// Pops bytes from the TX FIFO head and serialises them as start bit,
// 5-8 data bits (LSB first), optional parity bit and 1/1.5/2 stop bits.
// Bit timing is taken from the shared baud generator's oversample strobe.
// Optional feature macro: UART_TX_BREAK_EN (bc forces the line low).
module uart_tx_engine #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_pulse,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       bc,
    output logic       tx,
    output logic       busy,
    output logic       temt
);

    // Tick counter must hold the longest bit length (two stop bits).
    localparam int TW = $clog2(2 * OVERSAMPLE + 1);
    localparam logic [TW-1:0] BIT_LEN = TW'(OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      wls_q, wls_d;
    logic            stb_q, stb_d;
    logic            pen_q, pen_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;

    logic [TW-1:0]   bit_len;
    logic            bit_done;
    logic            last_data;

    // Parity over the active data bits only; stick parity overrides the data.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] w,
                                        input logic even, input logic stick);
        logic [7:0] masked;
        masked = data & (8'hFF >> (2'd3 - w));
        if (stick)
            return ~even;
        else if (even)
            return ^masked;
        else
            return ~(^masked);
    endfunction

    // Stop period: 1 bit, 1.5 bits for 5-bit words, otherwise 2 bits.
    function automatic logic [TW-1:0] stop_len(input logic two_stop, input logic [1:0] w);
        if (!two_stop)
            return TW'(OVERSAMPLE);
        else if (w == 2'b00)
            return TW'(3 * OVERSAMPLE / 2);
        else
            return TW'(2 * OVERSAMPLE);
    endfunction

    assign bit_len   = (state_q == S_STOP) ? stop_len(stb_q, wls_q) : BIT_LEN;
    assign bit_done  = baud_pulse && (tick_q == bit_len - 1'b1);
    assign last_data = (bit_q == {1'b1, wls_q});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each non-idle state advances when its bit period expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_START;
            S_START:  if (bit_done) state_d = S_DATA;
            S_DATA:   if (bit_done && last_data) state_d = pen_q ? S_PARITY : S_STOP;
            S_PARITY: if (bit_done) state_d = S_STOP;
            S_STOP:   if (bit_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: pop only from idle with data present and never while held in reset.
    always_comb begin
        fifo_pop = rst_n && (state_q == S_IDLE) && !fifo_empty;
        busy     = (state_q != S_IDLE);
        temt     = (state_q == S_IDLE) && fifo_empty;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // Datapath next state: frame settings are captured at pop so LCR writes
    // mid-frame only affect the following frame.
    always_comb begin
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wls_d   = wls_q;
        stb_d   = stb_q;
        pen_d   = pen_q;
        par_d   = par_q;
        if (state_q == S_IDLE) begin
            tick_d = '0;
            bit_d  = '0;
            if (!fifo_empty) begin
                shift_d = fifo_dout;
                wls_d   = wls;
                stb_d   = stb;
                pen_d   = pen;
                par_d   = parity_bit(fifo_dout, wls, eps, sp);
            end
        end else if (baud_pulse) begin
            if (bit_done) begin
                tick_d = '0;
                if (state_q == S_DATA) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    // Datapath and registered line level; reset returns the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wls_q   <= '0;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wls_q   <= wls_d;
            stb_q   <= stb_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_BREAK_EN
    // Break holds the line low; framing and pops carry on underneath.
    assign tx = tx_q & ~bc;
`else
    logic unused_bc;
    assign unused_bc = bc;
    assign tx = tx_q;
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine with a small FIFO model.
module tb_uart_tx_engine;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_pulse = 1'b0;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sp = 1'b0;
    logic       bc = 1'b0;
    logic       tx;
    logic       busy;
    logic       temt;

    uart_tx_engine #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_pulse (baud_pulse),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .wls        (wls),
        .stb        (stb),
        .pen        (pen),
        .eps        (eps),
        .sp         (sp),
        .bc         (bc),
        .tx         (tx),
        .busy       (busy),
        .temt       (temt)
    );

    always #5 clk = ~clk;

    // FIFO model: written by the stimulus, popped on the DUT's request.
    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = mem[rd_ptr];

    // Baud strobe: one clk high every baud_div clks.
    int baud_div = 3;
    int bcnt = 0;
    always @(negedge clk) begin
        if (bcnt >= baud_div - 1) begin
            baud_pulse = 1'b1;
            bcnt = 0;
        end else begin
            baud_pulse = 1'b0;
            bcnt = bcnt + 1;
        end
    end

    int cyc = 0, strobe_cnt = 0, busy_str = 0, pop_cnt = 0, underrun = 0;
    int last_pop = 0, prev_pop = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (baud_pulse) strobe_cnt <= strobe_cnt + 1;
        if (busy && baud_pulse) busy_str <= busy_str + 1;
        if (fifo_pop) begin
            rd_ptr   <= rd_ptr + 4'd1;
            pop_cnt  <= pop_cnt + 1;
            prev_pop <= last_pop;
            last_pop <= cyc;
            if (fifo_empty) underrun <= underrun + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic wait_strobe(input string tag, input int target);
        int n = 0;
        while (strobe_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=%0d expected=%0d", tag, strobe_cnt, target);
        end
    endtask

    task automatic wait_tx_low(input string tag, output int s0);
        int n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, {31'b0, tx}, 32'd0);
        s0 = strobe_cnt;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    // Sample the line mid-bit for each of n frame bits (bits[0] = start bit).
    task automatic check_frame(input string tag, input logic [11:0] bits, input int n,
                               output int s0);
        wait_tx_low(tag, s0);
        for (int i = 1; i < n; i++) begin
            wait_strobe(tag, s0 + OS * i + OS / 2);
            chk($sformatf("%s_bit%0d", tag, i), {31'b0, tx}, {31'b0, bits[i]});
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, b0, p0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_pop", {31'b0, fifo_pop}, 32'd0);
        chk("rst_temt", {31'b0, temt}, 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_tx", {31'b0, tx}, 32'd1);
        chk("idle_pop", {31'b0, fifo_pop}, 32'd0);

        // Test 1: 8N1, 0x55
        wls = 2'b11; pen = 1'b0; stb = 1'b0;
        b0 = busy_str; p0 = pop_cnt;
        push(8'h55);
        check_frame("t1", {2'b0, 1'b1, 8'h55, 1'b0}, 10, s0);
        wait_idle("t1");
        chk("t1_pops", pop_cnt - p0, 32'd1);
        chk("t1_strobes", busy_str - b0, 32'd160);
        repeat (2) @(negedge clk);
        chk("t1_temt", {31'b0, temt}, 32'd1);
        chk("t1_tx_idle", {31'b0, tx}, 32'd1);

        // Test 2: 7E1, 0x41; LCR rewritten mid-frame must not matter
        wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0;
        b0 = busy_str;
        push(8'h41);
        repeat (3) @(negedge clk);
        wls = 2'b11; pen = 1'b0; eps = 1'b0;
        check_frame("t2", {2'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, s0);
        wait_idle("t2");
        chk("t2_strobes", busy_str - b0, 32'd160);

        // Test 3: 5-bit stick parity, 1.5 stop bits, 0x1F
        wls = 2'b00; pen = 1'b1; sp = 1'b1; eps = 1'b0; stb = 1'b1;
        b0 = busy_str;
        push(8'h1F);
        check_frame("t3", {4'b0, 1'b1, 1'b1, 1'b1, 5'h1F, 1'b0}, 8, s0);
        wait_strobe("t3_stop", s0 + OS * 7 + 22);
        chk("t3_stop_busy", {31'b0, busy}, 32'd1);
        chk("t3_stop_tx", {31'b0, tx}, 32'd1);
        wait_idle("t3");
        chk("t3_strobes", busy_str - b0, 32'd136);
        wls = 2'b11; pen = 1'b0; sp = 1'b0; stb = 1'b0;

        // Test 4: back-to-back 8N1 frames, strobe every clk
        baud_div = 1;
        p0 = pop_cnt;
        @(negedge clk);
        mem[wr_ptr] = 8'hA5;
        mem[wr_ptr + 4'd1] = 8'h3C;
        wr_ptr = wr_ptr + 4'd2;
        check_frame("t4a", {2'b0, 1'b1, 8'hA5, 1'b0}, 10, s0);
        check_frame("t4b", {2'b0, 1'b1, 8'h3C, 1'b0}, 10, s0);
        wait_idle("t4");
        chk("t4_pops", pop_cnt - p0, 32'd2);
        chk("t4_pop_gap", last_pop - prev_pop, 32'd161);
        chk("t4_underrun", underrun, 32'd0);

        // Test 5: reset during data bit 3 of 0xC3 (that bit is 0)
        baud_div = 3;
        push(8'hC3);
        wait_tx_low("t5", s0);
        wait_strobe("t5", s0 + OS * 4 + OS / 2);
        chk("t5_pre_tx", {31'b0, tx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", {31'b0, tx}, 32'd1);
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        chk("t5_rst_pop", {31'b0, fifo_pop}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_temt", {31'b0, temt}, 32'd1);
        chk("t5_tx", {31'b0, tx}, 32'd1);
        chk("t5_busy", {31'b0, busy}, 32'd0);

        // Test 6: break control during an 8N1 frame of 0x55
        b0 = busy_str; p0 = pop_cnt;
        push(8'h55);
        bc = 1'b1;
`ifdef UART_TX_BREAK_EN
        begin
            int n = 0;
            while (busy !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t6_busy", {31'b0, busy}, 32'd1);
            s0 = strobe_cnt;
            for (int i = 0; i < 10; i++) begin
                wait_strobe("t6", s0 + OS * i + OS / 2);
                chk($sformatf("t6_brk%0d", i), {31'b0, tx}, 32'd0);
            end
        end
`else
        check_frame("t6", {2'b0, 1'b1, 8'h55, 1'b0}, 10, s0);
`endif
        wait_idle("t6");
        chk("t6_pops", pop_cnt - p0, 32'd1);
        chk("t6_strobes", busy_str - b0, 32'd160);
        bc = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_tx_idle", {31'b0, tx}, 32'd1);
        chk("t6_underrun", underrun, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
